// File: rtl/uart_pixel_loader.sv
// UART 8N1 receiver feeding row-major pixel writes into a frame buffer.
// Optional even parity bit: define UART_PARITY_EN.
module uart_pixel_loader #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int BAUD    = 115_200,
  parameter int IMG_W   = 160,
  parameter int IMG_H   = 120,
  parameter int ADDR_W  = 15,
  parameter int GAP_CYC = 5_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic              pix_we,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [7:0]        pix_data,
  output logic              frame_done,
  output logic              ferr,
  output logic              busy
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(DIV + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_M1 = CNT_W'(DIV - 1);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(NPIX - 1);
  localparam logic [GAP_W-1:0]  GAP_M1  = GAP_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, rxs;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              armed_q, armed_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pix_we_q, pix_we_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic [7:0]        pix_data_q, pix_data_d;
  logic              fdone_q, fdone_d;
  logic              ferr_q, ferr_d;
  logic              accept, start_det;
`ifdef UART_PARITY_EN
  logic              par_err_q, par_err_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      rxs     <= 1'b0;
    end else begin
      sync1_q <= rx;
      rxs     <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      armed_q    <= 1'b0;
      gap_q      <= '0;
      addr_q     <= '0;
      pix_we_q   <= 1'b0;
      pix_addr_q <= '0;
      pix_data_q <= '0;
      fdone_q    <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      armed_q    <= armed_d;
      gap_q      <= gap_d;
      addr_q     <= addr_d;
      pix_we_q   <= pix_we_d;
      pix_addr_q <= pix_addr_d;
      pix_data_q <= pix_data_d;
      fdone_q    <= fdone_d;
      ferr_q     <= ferr_d;
`ifdef UART_PARITY_EN
      par_err_q  <= par_err_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
    armed_d    = armed_q | rxs;
    gap_d      = gap_q;
    addr_d     = addr_q;
    pix_we_d   = 1'b0;
    pix_addr_d = pix_addr_q;
    pix_data_d = pix_data_q;
    fdone_d    = 1'b0;
    ferr_d     = 1'b0;
    accept     = 1'b0;
    start_det  = 1'b0;
`ifdef UART_PARITY_EN
    par_err_d  = par_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs && armed_q) begin
          start_det = 1'b1;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d   = S_PARITY;
            par_err_d = 1'b0;
`else
            state_d   = S_STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = S_STOP;
          if (rxs != ^shift_q) begin
            par_err_d = 1'b1;
            ferr_d    = 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rxs) begin
`ifdef UART_PARITY_EN
            accept = !par_err_q;
`else
            accept = 1'b1;
`endif
          end else begin
            // Line is low at stop: wait for it to return high before rearming.
            ferr_d  = 1'b1;
            armed_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      pix_we_d   = 1'b1;
      pix_data_d = shift_q;
      pix_addr_d = addr_q;
      if (addr_q == LAST) begin
        fdone_d = 1'b1;
        addr_d  = '0;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end

    // Start detection outranks a coincident gap timeout.
    if (start_det) begin
      gap_d = '0;
    end else if (state_q == S_IDLE && addr_q != '0) begin
      if (gap_q == GAP_M1) begin
        gap_d  = '0;
        addr_d = '0;
      end else begin
        gap_d = gap_q + GAP_W'(1);
      end
    end
  end

  assign pix_we     = pix_we_q;
  assign pix_addr   = pix_addr_q;
  assign pix_data   = pix_data_q;
  assign frame_done = fdone_q;
  assign ferr       = ferr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_pixel_loader.sv
// Bench for uart_pixel_loader: directed vector table, corner sequences, randomized frames vs model.
module tb_uart_pixel_loader;

  localparam int CLK_HZ  = 1_600_000;
  localparam int BAUD    = 100_000;
  localparam int DIV     = CLK_HZ / BAUD;
  localparam int IMG_W   = 4;
  localparam int IMG_H   = 2;
  localparam int NPIX    = IMG_W * IMG_H;
  localparam int ADDR_W  = 3;
  localparam int GAP_CYC = 1000;
`ifdef UART_PARITY_EN
  localparam int NBITS = 10;
`else
  localparam int NBITS = 9;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rx;
  logic              pix_we;
  logic [ADDR_W-1:0] pix_addr;
  logic [7:0]        pix_data;
  logic              frame_done;
  logic              ferr;
  logic              busy;

  uart_pixel_loader #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W),
    .GAP_CYC(GAP_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .pix_we    (pix_we),
    .pix_addr  (pix_addr),
    .pix_data  (pix_data),
    .frame_done(frame_done),
    .ferr      (ferr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit we;
    bit fe;
    bit fd;
    int data;
    int addr;
    int cyc;
  } ev_t;

  ev_t evq[$];
  bit  busy_seen = 1'b0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (busy) busy_seen = 1'b1;
      if (pix_we || ferr || frame_done)
        evq.push_back('{pix_we, ferr, frame_done, int'(pix_data), int'(pix_addr), cyc});
    end
  end

  int vectors = 0;
  int miscompares = 0;
  int last_fall = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] data, input bit stop, input bit par_bad);
    rx = 1'b0;
    last_fall = cyc;
    repeat (DIV) tick();
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (DIV) tick();
    end
`ifdef UART_PARITY_EN
    rx = (^data) ^ par_bad;
    repeat (DIV) tick();
`endif
    rx = stop;
    repeat (DIV) tick();
  endtask

  // Compare the events seen since the last call against one frame's expectation.
  task automatic check_frame(input string tag, input bit exp_we, input int exp_data,
                             input int exp_addr, input bit exp_fd, input int exp_ferr,
                             input int exp_cyc);
    int n_we, n_fe, n_fd;
    ev_t w;
    n_we = 0; n_fe = 0; n_fd = 0;
    w = '{0, 0, 0, 0, 0, 0};
    foreach (evq[i]) begin
      if (evq[i].we) begin n_we++; w = evq[i]; end
      if (evq[i].fe) n_fe++;
      if (evq[i].fd) n_fd++;
    end
    check({tag, ".writes"}, n_we, int'(exp_we));
    check({tag, ".ferr"}, n_fe, exp_ferr);
    check({tag, ".frame_done"}, n_fd, int'(exp_we && exp_fd));
    if (exp_we && n_we == 1) begin
      check({tag, ".data"}, w.data, exp_data);
      check({tag, ".addr"}, w.addr, exp_addr);
      if (exp_cyc >= 0) check({tag, ".latency"}, w.cyc, exp_cyc);
    end
    evq.delete();
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop;
    bit         par_bad;
    int         idle_before;
    bit         we;
    int         addr;
    bit         fd;
    int         nferr;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_addr;
    tbl[0]  = '{8'h00, 1'b1, 1'b0, 20,   1'b1, 0, 1'b0, 0};
    tbl[1]  = '{8'h01, 1'b1, 1'b0, 0,    1'b1, 1, 1'b0, 0};
    tbl[2]  = '{8'h02, 1'b1, 1'b0, 0,    1'b1, 2, 1'b0, 0};
    tbl[3]  = '{8'h03, 1'b1, 1'b0, 0,    1'b1, 3, 1'b0, 0};
    tbl[4]  = '{8'h04, 1'b1, 1'b0, 0,    1'b1, 4, 1'b0, 0};
    tbl[5]  = '{8'h05, 1'b1, 1'b0, 0,    1'b1, 5, 1'b0, 0};
    tbl[6]  = '{8'h06, 1'b1, 1'b0, 0,    1'b1, 6, 1'b0, 0};
    tbl[7]  = '{8'h07, 1'b1, 1'b0, 0,    1'b1, 7, 1'b1, 0};
    tbl[8]  = '{8'h08, 1'b1, 1'b0, 0,    1'b1, 0, 1'b0, 0};
    tbl[9]  = '{8'h3C, 1'b0, 1'b0, 0,    1'b0, 0, 1'b0, 1};
    tbl[10] = '{8'h11, 1'b1, 1'b0, 10,   1'b1, 1, 1'b0, 0};
    tbl[11] = '{8'h22, 1'b1, 1'b0, 0,    1'b1, 2, 1'b0, 0};
    tbl[12] = '{8'h33, 1'b1, 1'b0, 0,    1'b1, 3, 1'b0, 0};
    tbl[13] = '{8'h55, 1'b1, 1'b0, 1100, 1'b1, 0, 1'b0, 0};
    tbl[14] = '{8'h66, 1'b1, 1'b0, 500,  1'b1, 1, 1'b0, 0};

    // Reset values, with rx held low from time zero.
    rst_n = 1'b0;
    rx    = 1'b0;
    repeat (3) tick();
    check("rst.pix_we", int'(pix_we), 0);
    check("rst.pix_addr", int'(pix_addr), 0);
    check("rst.pix_data", int'(pix_data), 0);
    check("rst.frame_done", int'(frame_done), 0);
    check("rst.ferr", int'(ferr), 0);
    check("rst.busy", int'(busy), 0);

    rst_n = 1'b1;
    tick();
    busy_seen = 1'b0;
    repeat (20 * DIV) tick();
    check("lowrst.busy_seen", int'(busy_seen), 0);
    check_frame("lowrst", 1'b0, 0, 0, 1'b0, 0, -1);

    idle(20);
    send_frame(8'hA5, 1'b1, 1'b0);
    check_frame("first", 1'b1, 8'hA5, 0, 1'b0, 0, last_fall + 3 + DIV / 2 + NBITS * DIV);
    check("first.addr_hold", int'(pix_addr), 0);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    evq.delete();

    for (int i = 0; i < 15; i++) begin
      idle(tbl[i].idle_before);
      send_frame(tbl[i].data, tbl[i].stop, tbl[i].par_bad);
      check_frame($sformatf("vec%0d", i), tbl[i].we, int'(tbl[i].data), tbl[i].addr,
                  tbl[i].fd, tbl[i].nferr, -1);
    end

    // Short low glitch on an idle line.
    idle(20);
    busy_seen = 1'b0;
    evq.delete();
    rx = 1'b0;
    repeat (DIV / 4) tick();
    rx = 1'b1;
    repeat (3 * DIV) tick();
    check("glitch.busy_seen", int'(busy_seen), 1);
    check_frame("glitch", 1'b0, 0, 0, 1'b0, 0, -1);

`ifdef UART_PARITY_EN
    idle(20);
    send_frame(8'h01, 1'b1, 1'b1);
    check_frame("parity", 1'b0, 0, 0, 1'b0, 1, -1);
`endif

    // Reset in the middle of a byte and of a frame.
    idle(20);
    rx = 1'b0;
    repeat (5 * DIV) tick();
    check("midrst.busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("midrst.busy", int'(busy), 0);
    check("midrst.pix_addr", int'(pix_addr), 0);
    check("midrst.pix_we", int'(pix_we), 0);
    rx = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    evq.delete();

    // Randomized frames against a pixel-position model.
    exp_addr = 0;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      bit bad_stop, par_bad, long_gap, ok;
      int gap, nf;
      d        = 8'($urandom);
      bad_stop = ($urandom_range(0, 7) == 0);
`ifdef UART_PARITY_EN
      par_bad  = ($urandom_range(0, 7) == 0);
`else
      par_bad  = 1'b0;
`endif
      long_gap = (n > 0) && ($urandom_range(0, 5) == 0);
      gap      = long_gap ? 1100 + $urandom_range(0, 99) : 4 + $urandom_range(0, 59);
      if (n == 0) gap = 20;
      if (long_gap) exp_addr = 0;
      idle(gap);
      send_frame(d, !bad_stop, par_bad);
      ok = !bad_stop && !par_bad;
      nf = int'(bad_stop) + int'(par_bad);
      check_frame($sformatf("rnd%0d", n), ok, int'(d), exp_addr, exp_addr == NPIX - 1, nf, -1);
      if (ok) exp_addr = (exp_addr + 1) % NPIX;
    end

    idle(10);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
